risc_v_mike_imm_decode_stage: RTL and testbench

Decode-stage front end that sits between fetch and execute.
- Classifies each fetched instruction by opcode and derives the immediate-format select.
- Drives the existing immediate sign-extension unit and registers the extended immediate, instruction and PC into a valid/ready pipeline register.
- A two-entry skid buffer keeps in_ready registered while sustaining one instruction per cycle; flush support and an illegal-opcode counter are included.

---
 rtl/risc_v_mike_pkg.sv | 43 ++++
 rtl/risc_v_mike_sign_extend.sv | 25 ++
 rtl/risc_v_mike_imm_decode_stage.sv | 151 +++++++++++++++
 tb/tb_risc_v_mike_imm_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike decode front end.
// Opcode map, immediate-format select and the decoded-entry record.
package risc_v_mike_pkg;

  localparam int INSTR_32_W = 32;
  localparam int DATA_32_W  = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [INSTR_32_W-1:0] instr;
    logic [DATA_32_W-1:0]  pc;
    logic [DATA_32_W-1:0]  imm_ext;
    imm_src_e              imm_src;
    logic                  imm_used;
    logic                  illegal;
  } dec_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/risc_v_mike_sign_extend.sv
// Immediate sign-extension unit: assembles the I/S/B/J/U immediate.
// Opcode bits are not needed here, so only instr[31:7] is taken.
module risc_v_mike_sign_extend
  import risc_v_mike_pkg::*;
(
  input  logic [INSTR_32_W-1:7] i_instr,
  input  imm_src_e              i_imm_src,
  output logic [DATA_32_W-1:0]  o_imm_ext
);

  always_comb begin
    o_imm_ext = '0;
    case (i_imm_src)
      IMM_I: o_imm_ext = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm_ext = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm_ext = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J: o_imm_ext = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      IMM_U: o_imm_ext = {i_instr[31:12], 12'b0};
      default: o_imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/risc_v_mike_imm_decode_stage.sv
// Decode-stage front end: opcode classification, immediate extension and a
// two-entry (main + skid) valid/ready output register with registered in_ready.
module risc_v_mike_imm_decode_stage
  import risc_v_mike_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_32_W-1:0] in_instr,
  input  logic [DATA_32_W-1:0]  in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_32_W-1:0] out_instr,
  output logic [DATA_32_W-1:0]  out_pc,
  output logic [DATA_32_W-1:0]  out_imm_ext,
  output logic [2:0]            out_imm_src,
  output logic                  out_imm_used,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      illegal_cnt
);

  imm_src_e              w_imm_src;
  logic                  w_imm_used;
  logic                  w_illegal;
  logic [DATA_32_W-1:0]  w_sext;
  dec_entry_t            w_dec;
  dec_entry_t            r_main;
  dec_entry_t            r_skid;
  occ_state_e            r_state;
  occ_state_e            w_state_nxt;
  logic                  r_in_ready;
  logic [CNT_W-1:0]      r_illegal_cnt;
  logic                  w_accept;
  logic                  w_load_main;
  logic                  w_load_skid;
  logic                  w_skid_to_main;

  always_comb begin
    w_imm_src  = IMM_I;
    w_imm_used = 1'b1;
    w_illegal  = 1'b0;
    case (in_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: w_imm_src = IMM_I;
      OPC_STORE:            w_imm_src = IMM_S;
      OPC_BRANCH:           w_imm_src = IMM_B;
      OPC_JAL:              w_imm_src = IMM_J;
      OPC_LUI, OPC_AUIPC:   w_imm_src = IMM_U;
      OPC_OP, OPC_FENCE:    w_imm_used = 1'b0;
      default: begin
        w_imm_used = 1'b0;
        w_illegal  = 1'b1;
      end
    endcase
  end

  risc_v_mike_sign_extend u_sign_extend (
    .i_instr   (in_instr[INSTR_32_W-1:7]),
    .i_imm_src (w_imm_src),
    .o_imm_ext (w_sext)
  );

  // The extender's output is meaningless for no-immediate and illegal opcodes.
  always_comb begin
    w_dec          = '0;
    w_dec.instr    = in_instr;
    w_dec.pc       = in_pc;
    w_dec.imm_ext  = w_imm_used ? w_sext : '0;
    w_dec.imm_src  = w_imm_src;
    w_dec.imm_used = w_imm_used;
    w_dec.illegal  = w_illegal;
  end

  assign w_accept = in_valid & r_in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_accept && !out_ready)      w_state_nxt = ST_FULL;
          else if (!w_accept && out_ready) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (out_ready) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid      = (r_state != ST_EMPTY);
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: w_load_main = w_accept;
      ST_ONE: begin
        w_load_main = w_accept & out_ready;
        w_load_skid = w_accept & ~out_ready;
      end
      ST_FULL:  w_skid_to_main = out_ready & ~flush;
      default: ;
    endcase
  end

  // in_ready comes from the next state so it is a flop output, not a comb path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in_ready <= 1'b1;
    else        r_in_ready <= (w_state_nxt != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main)         r_main <= w_dec;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid)         r_skid <= w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_accept && w_dec.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_instr    = r_main.instr;
  assign out_pc       = r_main.pc;
  assign out_imm_ext  = r_main.imm_ext;
  assign out_imm_src  = r_main.imm_src;
  assign out_imm_used = r_main.imm_used;
  assign out_illegal  = r_main.illegal;
  assign illegal_cnt  = r_illegal_cnt;

endmodule

// File: tb/tb_risc_v_mike_imm_decode_stage.sv
// Bench for the decode stage: fixed vector table, directed backpressure /
// flush / reset sequences and a random phase against a queue-based model.
module tb_risc_v_mike_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_imm_used, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm_ext;
  logic [2:0]  out_imm_src;
  logic [15:0] illegal_cnt;

  logic        in_ready2, out_valid2, out_imm_used2, out_illegal2;
  logic [31:0] out_instr2, out_pc2, out_imm_ext2;
  logic [2:0]  out_imm_src2;
  logic [1:0]  illegal_cnt2;

  risc_v_mike_imm_decode_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_imm_ext(out_imm_ext),
    .out_imm_src(out_imm_src), .out_imm_used(out_imm_used), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  risc_v_mike_imm_decode_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_pc(out_pc2), .out_imm_ext(out_imm_ext2),
    .out_imm_src(out_imm_src2), .out_imm_used(out_imm_used2), .out_illegal(out_illegal2),
    .illegal_cnt(illegal_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  src;
    logic        used;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    exp_t        e;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  src;
    logic        used;
    logic        ill;
  } vec_t;

  int   n_err = 0;
  int   n_chk = 0;
  ent_t q[$];
  int   cnt16 = 0;
  int   cnt2  = 0;
  vec_t vecs[10];

  // Reference decode: immediates built from bit-field weights, not bit concatenation.
  function automatic exp_t ref_dec(input logic [31:0] ins);
    exp_t r;
    int   v;
    r.imm = '0; r.src = 3'd0; r.used = 1'b1; r.ill = 1'b0; v = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        v = int'(ins[31:20]); if (ins[31]) v -= 4096;
        r.src = 3'd0; r.imm = v;
      end
      7'h23: begin
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]); if (ins[31]) v -= 4096;
        r.src = 3'd1; r.imm = v;
      end
      7'h63: begin
        v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) v -= 4096;
        r.src = 3'd2; r.imm = v;
      end
      7'h6F: begin
        v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (ins[31]) v -= (1 << 20);
        r.src = 3'd3; r.imm = v;
      end
      7'h37, 7'h17: begin
        r.src = 3'd4; r.imm = ins & 32'hFFFFF000;
      end
      7'h33, 7'h0F: r.used = 1'b0;
      default: begin r.used = 1'b0; r.ill = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(cnt16));
    chk("illegal_cnt2", 32'(illegal_cnt2), 32'(cnt2));
    if (q.size() > 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_imm_ext", out_imm_ext, q[0].e.imm);
      chk("out_imm_src", 32'(out_imm_src), 32'(q[0].e.src));
      chk("out_imm_used", 32'(out_imm_used), 32'(q[0].e.used));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].e.ill));
    end
  endtask

  task automatic model_reset();
    q.delete();
    cnt16 = 0;
    cnt2  = 0;
  endtask

  // One clock: predict from pre-edge inputs, update after the edge, check at +1.
  task automatic step();
    bit   cons, acc;
    ent_t n;
    cons = (q.size() > 0) && out_ready;
    acc  = in_valid && (q.size() < 2) && !flush;
    n.instr = in_instr;
    n.pc    = in_pc;
    n.e     = ref_dec(in_instr);
    @(posedge clk);
    if (cons) void'(q.pop_front());
    if (flush) q.delete();
    if (acc) begin
      q.push_back(n);
      if (n.e.ill) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt2 < 3) cnt2++;
      end
    end
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic chk_vec(input string tag, input int i);
    chk({tag, " imm"}, out_imm_ext, vecs[i].imm);
    chk({tag, " src"}, 32'(out_imm_src), 32'(vecs[i].src));
    chk({tag, " used"}, 32'(out_imm_used), 32'(vecs[i].used));
    chk({tag, " ill"}, 32'(out_illegal), 32'(vecs[i].ill));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [6:0]  opcs[11];

    vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{32'h0020A423, 32'h00000008, 3'd1, 1'b1, 1'b0};
    vecs[2] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 1'b1, 1'b0};
    vecs[3] = '{32'h123452B7, 32'h12345000, 3'd4, 1'b1, 1'b0};
    vecs[4] = '{32'h00000000, 32'h00000000, 3'd0, 1'b0, 1'b1};
    vecs[5] = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000000F, 32'h00000000, 3'd0, 1'b0, 1'b0};
    vecs[7] = '{32'h008000EF, 32'h00000008, 3'd3, 1'b1, 1'b0};
    vecs[8] = '{32'h00001097, 32'h00001000, 3'd4, 1'b1, 1'b0};
    vecs[9] = '{32'h00402103, 32'h00000004, 3'd0, 1'b1, 1'b0};
    opcs = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F};

    // Reset state
    #12;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_instr", out_instr, 32'd0);
    chk("rst out_imm_ext", out_imm_ext, 32'd0);
    chk("rst illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single accepts with out_ready held high
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
      step();
      chk_vec("vec", i);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
    end

    // Back-to-back sw, beq, lui
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, vecs[i].instr, 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
      step();
      chk_vec("b2b", i);
      chk("b2b in_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Backpressure fills the skid, then drains in order
    drive(1'b1, vecs[0].instr, 32'h3000, 1'b0, 1'b0); step();
    drive(1'b1, vecs[1].instr, 32'h3004, 1'b0, 1'b0); step();
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    drive(1'b1, vecs[3].instr, 32'h3008, 1'b0, 1'b0); step(); step();
    chk("bp hold first", out_instr, vecs[0].instr);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); step();
    chk("bp second", out_instr, vecs[1].instr);
    chk("bp in_ready back", 32'(in_ready), 32'd1);
    step(); step();

    // Illegal accepts: narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0, 32'h4000 + 32'(4 * i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); step();
    chk("cnt2 saturated", 32'(illegal_cnt2), 32'd3);

    // Flush while FULL with an input pending
    drive(1'b1, vecs[0].instr, 32'h5000, 1'b0, 1'b0); step();
    drive(1'b1, vecs[2].instr, 32'h5004, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0, 32'h5008, 1'b0, 1'b1); step();
    chk("flush full out_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); step(); step();

    // Flush while ONE with an illegal input pending: not counted
    drive(1'b1, vecs[0].instr, 32'h5100, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0, 32'h5104, 1'b1, 1'b1); step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); step(); step();

    // Asynchronous reset while FULL
    drive(1'b1, vecs[4].instr, 32'h6000, 1'b0, 1'b0); step();
    drive(1'b1, vecs[1].instr, 32'h6004, 1'b0, 1'b0); step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, vecs[0].instr, 32'h7000, 1'b1, 1'b0); step();
    chk_vec("post-rst", 0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      if ($urandom_range(0, 11) == 11) r[6:0] = 7'($urandom());
      else r[6:0] = opcs[$urandom_range(0, 10)];
      drive(1'($urandom_range(0, 3) != 0), r, $urandom(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
